sram_port_ctrl: RTL

Request-side controller sitting directly upstream of the 32×16 two-port SRAM array in `sram_2port_bank`. It accepts one command at a time over a valid/ready handshake (read both ports, or write one data word to one or two rows) and decodes the 5-bit addresses into the array's one-hot `wordA`/`wordB` lines. It sequences `ReadEn`/`WriteEn` so each command produces a fresh rising enable edge, captures the array's `outA`/`outB`, and returns them over a valid/ready response channel.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_word_dec.sv | 17 +
 rtl/sram_port_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared widths and enums for the two-port SRAM request controller.
package sram_pkg;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int WORDS = 1 << AW;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/sram_word_dec.sv
// Row address to one-hot word-line decoder; all lines low when i_en is low.
module sram_word_dec
    import sram_pkg::*;
(
    input  logic [AW-1:0]    i_addr,
    input  logic             i_en,
    output logic [WORDS-1:0] o_word
);

    always_comb begin
        o_word = '0;
        if (i_en) begin
            o_word[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// One-command-at-a-time request controller for the 32x16 two-port SRAM array.
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// SETUP   | word lines, data and enable driven to the array
// ACCESS  | everything held; array acts on the edge ending this cycle
// CAPTURE | enables low, array read data registered
// RESP    | rsp_valid high until rsp_ready
module sram_port_ctrl
    import sram_pkg::*;
(
    input  logic             srclkpos,
    input  logic             rstneg,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addra,
    input  logic [AW-1:0]    cmd_addrb,
    input  logic [DW-1:0]    cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdataa,
    output logic [DW-1:0]    rsp_rdatab,
    output logic             wr_done,
    output logic             wr_zero_err,
    output logic [WORDS-1:0] wordA,
    output logic [WORDS-1:0] wordB,
    output logic             ReadEn,
    output logic             WriteEn,
    output logic [DW-1:0]    in,
    input  logic [DW-1:0]    outA,
    input  logic [DW-1:0]    outB
);

    ctrl_state_t      r_state, w_state_nxt;
    op_t              r_op, w_op_sel;
    logic [AW-1:0]    r_addr_a, r_addr_b, w_addr_a_sel, w_addr_b_sel;
    logic [DW-1:0]    r_wdata, w_wdata_sel;
    logic             w_cmd_fire, w_en_nxt, w_wr_done_nxt, w_rsp_valid_nxt;
    logic [WORDS-1:0] w_word_a, w_word_b;
    logic [WORDS-1:0] r_word_a, r_word_b;
    logic             r_read_en, r_write_en, r_wr_done, r_rsp_valid, r_zero_err;
    logic [DW-1:0]    r_in, r_rdata_a, r_rdata_b;

    assign w_cmd_fire = cmd_valid && (r_state == IDLE);

    // Registered array outputs load on the handshake edge, so SETUP sees the new command directly.
    assign w_op_sel     = w_cmd_fire ? op_t'(cmd_we) : r_op;
    assign w_addr_a_sel = (r_state == IDLE) ? cmd_addra : r_addr_a;
    assign w_addr_b_sel = (r_state == IDLE) ? cmd_addrb : r_addr_b;
    assign w_wdata_sel  = (r_state == IDLE) ? cmd_wdata : r_wdata;

    always_ff @(posedge srclkpos or negedge rstneg) begin
        if (!rstneg) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = (r_op == OP_WR) ? IDLE : CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = (r_state == IDLE);
        w_en_nxt        = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
        w_wr_done_nxt   = (r_state == ACCESS) && (r_op == OP_WR);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
    end

    sram_word_dec u_dec_a (
        .i_addr (w_addr_a_sel),
        .i_en   (w_en_nxt),
        .o_word (w_word_a)
    );

    sram_word_dec u_dec_b (
        .i_addr (w_addr_b_sel),
        .i_en   (w_en_nxt),
        .o_word (w_word_b)
    );

    always_ff @(posedge srclkpos or negedge rstneg) begin
        if (!rstneg) begin
            r_op       <= OP_RD;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_wdata    <= '0;
            r_zero_err <= 1'b0;
        end else if (w_cmd_fire) begin
            r_op     <= op_t'(cmd_we);
            r_addr_a <= cmd_addra;
            r_addr_b <= cmd_addrb;
            r_wdata  <= cmd_wdata;
            if (cmd_we && ((cmd_addra == '0) || (cmd_addrb == '0))) begin
                r_zero_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge srclkpos or negedge rstneg) begin
        if (!rstneg) begin
            r_word_a    <= '0;
            r_word_b    <= '0;
            r_read_en   <= 1'b0;
            r_write_en  <= 1'b0;
            r_in        <= '0;
            r_wr_done   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
        end else begin
            r_word_a    <= w_word_a;
            r_word_b    <= w_word_b;
            r_read_en   <= w_en_nxt && (w_op_sel == OP_RD);
            r_write_en  <= w_en_nxt && (w_op_sel == OP_WR);
            r_in        <= w_en_nxt ? w_wdata_sel : '0;
            r_wr_done   <= w_wr_done_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (r_state == CAPTURE) begin
                r_rdata_a <= outA;
                r_rdata_b <= outB;
            end
        end
    end

    assign wordA       = r_word_a;
    assign wordB       = r_word_b;
    assign ReadEn      = r_read_en;
    assign WriteEn     = r_write_en;
    assign in          = r_in;
    assign wr_done     = r_wr_done;
    assign wr_zero_err = r_zero_err;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdataa  = r_rdata_a;
    assign rsp_rdatab  = r_rdata_b;

endmodule
